mc_ctrl_fsm_hs: RTL and testbench

Parametrised multicycle control unit for the 16-bit datapath, replacing the fixed-latency controller.
- Adds a variable-latency memory handshake (mem_req/mem_ready) on instruction fetch, load and store.
- Adds a memory timeout, an illegal-instruction trap and an explicit register write-back for ALU ops.
- Drives every datapath mux, enable and write strobe; sits between the IR/opcode decode and the datapath/memory.

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_ctrl_fsm_hs_if.sv | 44 ++++
 rtl/mc_mem_wait_timer.sv | 33 +++
 rtl/mc_ctrl_fsm_hs.sv | 226 ++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm_hs.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes, datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExAlu  = 4'd2,
    StWbAlu  = 4'd3,
    StExBr   = 4'd4,
    StExJmp  = 4'd5,
    StExAddr = 4'd6,
    StMemLw  = 4'd7,
    StWbLw   = 4'd8,
    StMemSw  = 4'd9,
    StTrap   = 4'd10
  } state_e;

  typedef enum logic [2:0] {
    ClsIllegal, ClsAlu, ClsBr, ClsJmp, ClsLw, ClsSw
  } instr_cls_e;

  localparam logic [3:0] OpShift = 4'b0000;
  localparam logic [3:0] OpLw    = 4'b0001;
  localparam logic [3:0] OpSw    = 4'b0010;
  localparam logic [3:0] OpJmp   = 4'b0011;
  localparam logic [3:0] OpBeq   = 4'b0100;
  localparam logic [3:0] OpBnq   = 4'b0101;
  localparam logic [3:0] OpOri   = 4'b0110;
  localparam logic [3:0] OpNandi = 4'b0111;
  localparam logic [3:0] OpAdd   = 4'b1000;
  localparam logic [3:0] OpAddi1 = 4'b1001;
  localparam logic [3:0] OpAddi2 = 4'b1010;
  localparam logic [3:0] OpNand  = 4'b1011;
  localparam logic [3:0] OpSub   = 4'b1100;
  localparam logic [3:0] OpSubi1 = 4'b1101;
  localparam logic [3:0] OpSubi2 = 4'b1110;
  localparam logic [3:0] OpOr    = 4'b1111;

  localparam logic [3:0] FuncSrl = 4'd1;
  localparam logic [3:0] FuncSll = 4'd2;
  localparam logic [3:0] FuncSra = 4'd3;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluNand = 3'b010;
  localparam logic [2:0] AluSrl  = 3'b011;
  localparam logic [2:0] AluSll  = 3'b100;
  localparam logic [2:0] AluOr   = 3'b101;
  localparam logic [2:0] AluSra  = 3'b111;

  localparam logic [2:0] SrcBReg    = 3'b000;
  localparam logic [2:0] SrcBOne    = 3'b001;
  localparam logic [2:0] SrcBImm    = 3'b010;
  localparam logic [2:0] SrcBMemOff = 3'b011;
  localparam logic [2:0] SrcBJmpOff = 3'b100;

  localparam logic [1:0] PcAlu  = 2'b00;
  localparam logic [1:0] PcJump = 2'b01;
  localparam logic [1:0] PcTrap = 2'b10;

  localparam logic [1:0] CauseNone    = 2'b00;
  localparam logic [1:0] CauseIllegal = 2'b01;
  localparam logic [1:0] CauseTimeout = 2'b10;

  // A disabled timeout still needs a 1-bit counter to keep widths legal.
  function automatic int unsigned cnt_width(int unsigned timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_hs_if.sv
// Controller <-> IR/datapath/memory bundle; master is the controller, slave the datapath side.
interface mc_ctrl_fsm_hs_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned FUNC_W   = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func_field;
  logic                mem_ready;
  logic                mem_req;
  logic [1:0]          PCSrc;
  logic [2:0]          ALUOp;
  logic                sign_extend;
  logic                ALUSrcA;
  logic [2:0]          ALUSrcB;
  logic [1:0]          ReadR1;
  logic                ReadR2;
  logic                RegWriteDst;
  logic                MemToReg;
  logic                PCBEqCond;
  logic                PCBNqCond;
  logic                PCWrite;
  logic                MemWrite;
  logic                MemRead;
  logic                IRWrite;
  logic                RegWrite;
  logic                trap_valid;
  logic [1:0]          trap_cause;
  logic                retire;
  logic [3:0]          state_o;

  modport master (
    input  opcode, func_field, mem_ready,
    output mem_req, PCSrc, ALUOp, sign_extend, ALUSrcA, ALUSrcB, ReadR1, ReadR2,
           RegWriteDst, MemToReg, PCBEqCond, PCBNqCond, PCWrite, MemWrite, MemRead,
           IRWrite, RegWrite, trap_valid, trap_cause, retire, state_o
  );

  modport slave (
    output opcode, func_field, mem_ready,
    input  mem_req, PCSrc, ALUOp, sign_extend, ALUSrcA, ALUSrcB, ReadR1, ReadR2,
           RegWriteDst, MemToReg, PCBEqCond, PCBNqCond, PCWrite, MemWrite, MemRead,
           IRWrite, RegWrite, trap_valid, trap_cause, retire, state_o
  );
endinterface

// File: rtl/mc_mem_wait_timer.sv
// Counts cycles a memory access is held without mem_ready; flags the configured limit.
module mc_mem_wait_timer #(
  parameter int unsigned MemTimeout = 15,
  parameter int unsigned CntW       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic hold_i,
  output logic timeout_o
);
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (hold_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = (MemTimeout != 0) && (cnt_q == CntW'(MemTimeout));

endmodule

// File: rtl/mc_ctrl_fsm_hs.sv
// Multicycle control FSM with variable-latency memory handshake, timeout and illegal-op trap.
module mc_ctrl_fsm_hs
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W        = 4,
  parameter int unsigned FUNC_W          = 4,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  mc_ctrl_fsm_hs_if.master  bus
);
  localparam int unsigned CntW = cnt_width(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [1:0]    cause_q, cause_d;
  logic          timeout, in_mem;
  logic [OPCODE_W-1:0] op_raw;
  logic [FUNC_W-1:0]   fn_raw;
  logic [3:0]    op, fn;
  logic          op_ok, fn_ok;
  instr_cls_e    cls;
  logic [2:0]    alu_op;
  logic          use_imm, imm_sext;

  // Wider fields are zero-extended encodings: any set upper bit makes them undefined.
  assign op_raw = bus.opcode;
  assign fn_raw = bus.func_field;
  assign op     = op_raw[3:0];
  assign fn     = fn_raw[3:0];
  assign op_ok  = (op_raw == OPCODE_W'(op));
  assign fn_ok  = (fn_raw == FUNC_W'(fn));

  always_comb begin
    cls      = ClsIllegal;
    alu_op   = AluAdd;
    use_imm  = 1'b0;
    imm_sext = 1'b0;
    if (op_ok) begin
      case (op)
        OpAdd:   cls = ClsAlu;
        OpAddi1: begin cls = ClsAlu; use_imm = 1'b1; imm_sext = 1'b1; end
        OpAddi2: begin cls = ClsAlu; use_imm = 1'b1; end
        OpSub:   begin cls = ClsAlu; alu_op = AluSub; end
        OpSubi1: begin cls = ClsAlu; alu_op = AluSub; use_imm = 1'b1; imm_sext = 1'b1; end
        OpSubi2: begin cls = ClsAlu; alu_op = AluSub; use_imm = 1'b1; end
        OpNand:  begin cls = ClsAlu; alu_op = AluNand; end
        OpNandi: begin cls = ClsAlu; alu_op = AluNand; use_imm = 1'b1; end
        OpOr:    begin cls = ClsAlu; alu_op = AluOr; end
        OpOri:   begin cls = ClsAlu; alu_op = AluOr; use_imm = 1'b1; imm_sext = 1'b1; end
        OpShift: begin
          if (fn_ok) begin
            case (fn)
              FuncSrl: begin cls = ClsAlu; alu_op = AluSrl; end
              FuncSll: begin cls = ClsAlu; alu_op = AluSll; end
              FuncSra: begin cls = ClsAlu; alu_op = AluSra; end
              default: cls = ClsIllegal;
            endcase
          end
        end
        OpBeq, OpBnq: cls = ClsBr;
        OpJmp:        cls = ClsJmp;
        OpLw:         cls = ClsLw;
        OpSw:         cls = ClsSw;
        default:      cls = ClsIllegal;
      endcase
    end
  end

  assign in_mem = (state_q == StFetch) || (state_q == StMemLw) || (state_q == StMemSw);

  mc_mem_wait_timer #(
    .MemTimeout (MEM_TIMEOUT),
    .CntW       (CntW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_d != state_q),
    .hold_i    (in_mem && !bus.mem_ready),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d         = state_q;
    cause_d         = cause_q;
    bus.mem_req     = 1'b0;
    bus.PCSrc       = PcAlu;
    bus.ALUOp       = AluAdd;
    bus.sign_extend = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = SrcBReg;
    bus.ReadR1      = 2'b00;
    bus.ReadR2      = 1'b0;
    bus.RegWriteDst = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.PCBEqCond   = 1'b0;
    bus.PCBNqCond   = 1'b0;
    bus.PCWrite     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.trap_valid  = 1'b0;
    bus.retire      = 1'b0;
    unique case (state_q)
      StFetch: begin
        bus.mem_req = 1'b1;
        bus.MemRead = 1'b1;
        bus.ALUSrcB = SrcBOne;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          state_d     = StDecode;
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StDecode: begin
        bus.ALUSrcB = SrcBOne;
        case (cls)
          ClsAlu:       state_d = StExAlu;
          ClsBr:        state_d = StExBr;
          ClsJmp:       state_d = StExJmp;
          ClsLw, ClsSw: state_d = StExAddr;
          default: begin
            if (TRAP_ON_ILLEGAL) begin
              state_d = StTrap;
              cause_d = CauseIllegal;
            end else begin
              state_d = StFetch;
            end
          end
        endcase
      end
      StExAlu: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = alu_op;
        bus.ALUSrcB     = use_imm ? SrcBImm : SrcBReg;
        bus.ReadR1      = use_imm ? 2'b01 : 2'b00;
        bus.sign_extend = imm_sext;
        state_d         = StWbAlu;
      end
      StWbAlu: begin
        bus.RegWrite    = 1'b1;
        bus.RegWriteDst = 1'b1;
        bus.retire      = 1'b1;
        state_d         = StFetch;
      end
      StExBr: begin
        bus.ALUOp     = AluSub;
        bus.ALUSrcA   = 1'b1;
        bus.ReadR1    = 2'b01;
        bus.PCBEqCond = (op == OpBeq);
        bus.PCBNqCond = (op == OpBnq);
        bus.retire    = 1'b1;
        state_d       = StFetch;
      end
      StExJmp: begin
        bus.PCSrc   = PcJump;
        bus.ALUSrcB = SrcBJmpOff;
        bus.PCWrite = 1'b1;
        bus.retire  = 1'b1;
        state_d     = StFetch;
      end
      StExAddr: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = SrcBMemOff;
        bus.ReadR1      = 2'b10;
        bus.ReadR2      = 1'b1;
        bus.sign_extend = 1'b1;
        state_d         = (cls == ClsSw) ? StMemSw : StMemLw;
      end
      StMemLw: begin
        bus.mem_req = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.mem_ready) begin
          state_d = StWbLw;
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StWbLw: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        bus.retire   = 1'b1;
        state_d      = StFetch;
      end
      StMemSw: begin
        bus.mem_req  = 1'b1;
        bus.MemWrite = 1'b1;
        bus.ReadR2   = 1'b1;
        if (bus.mem_ready) begin
          bus.retire = 1'b1;
          state_d    = StFetch;
        end else if (timeout) begin
          state_d = StTrap;
          cause_d = CauseTimeout;
        end
      end
      StTrap: begin
        bus.PCSrc      = PcTrap;
        bus.PCWrite    = 1'b1;
        bus.trap_valid = 1'b1;
        state_d        = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cause_q <= CauseNone;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  assign bus.trap_cause = cause_q;
  assign bus.state_o    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm_hs.sv
// Randomised scoreboard bench: dut0 traps (timeout 15), dut1 ignores illegal ops, no timeout.
module tb_mc_ctrl_fsm_hs;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic       mem_req;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       sext;
    logic       src_a;
    logic [2:0] src_b;
    logic [1:0] rr1;
    logic       rr2;
    logic       rwd;
    logic       m2r;
    logic       beq;
    logic       bnq;
    logic       pcw;
    logic       mw;
    logic       mr;
    logic       irw;
    logic       rw;
    logic       tv;
    logic [1:0] tc;
    logic       ret;
    logic [3:0] st;
  } outv_t;

  localparam int CIll = 0, CAlu = 1, CBr = 2, CJmp = 3, CLw = 4, CSw = 5;

  logic clk = 1'b0;
  logic rst0 = 1'b1, rst1 = 1'b1;
  always #5 clk = ~clk;

  mc_ctrl_fsm_hs_if #(.OPCODE_W(4), .FUNC_W(4)) bus0 ();
  mc_ctrl_fsm_hs_if #(.OPCODE_W(4), .FUNC_W(4)) bus1 ();

  mc_ctrl_fsm_hs #(
    .OPCODE_W(4), .FUNC_W(4), .MEM_TIMEOUT(15), .TRAP_ON_ILLEGAL(1'b1)
  ) u_dut0 (
    .clk (clk), .rst (rst0), .bus (bus0.master)
  );

  mc_ctrl_fsm_hs #(
    .OPCODE_W(4), .FUNC_W(4), .MEM_TIMEOUT(0), .TRAP_ON_ILLEGAL(1'b0)
  ) u_dut1 (
    .clk (clk), .rst (rst1), .bus (bus1.master)
  );

  outv_t act0, act1;
  assign act0 = {bus0.mem_req, bus0.PCSrc, bus0.ALUOp, bus0.sign_extend, bus0.ALUSrcA,
                 bus0.ALUSrcB, bus0.ReadR1, bus0.ReadR2, bus0.RegWriteDst, bus0.MemToReg,
                 bus0.PCBEqCond, bus0.PCBNqCond, bus0.PCWrite, bus0.MemWrite, bus0.MemRead,
                 bus0.IRWrite, bus0.RegWrite, bus0.trap_valid, bus0.trap_cause, bus0.retire,
                 bus0.state_o};
  assign act1 = {bus1.mem_req, bus1.PCSrc, bus1.ALUOp, bus1.sign_extend, bus1.ALUSrcA,
                 bus1.ALUSrcB, bus1.ReadR1, bus1.ReadR2, bus1.RegWriteDst, bus1.MemToReg,
                 bus1.PCBEqCond, bus1.PCBNqCond, bus1.PCWrite, bus1.MemWrite, bus1.MemRead,
                 bus1.IRWrite, bus1.RegWrite, bus1.trap_valid, bus1.trap_cause, bus1.retire,
                 bus1.state_o};

  int unsigned tmo [2] = '{15, 0};
  bit          toi [2] = '{1'b1, 1'b0};
  logic [1:0]  cause_m [2] = '{2'b00, 2'b00};
  outv_t q0 [$], q1 [$];
  int    id0 [$], id1 [$];
  int    instr_id = 0;
  int    n_chk = 0, n_pass = 0;

  task automatic chk(input int d, input outv_t a, input outv_t e, input int id);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL dut%0d instr%0d outputs: got %h required %h (state got %0d required %0d)",
                  d, id, a, e, a.st, e.st);
  endtask

  always @(negedge clk) begin
    if (q0.size() != 0) chk(0, act0, q0.pop_front(), id0.pop_front());
    if (q1.size() != 0) chk(1, act1, q1.pop_front(), id1.pop_front());
  end

  function automatic outv_t base(input int d, input state_e s);
    outv_t e;
    e    = '0;
    e.st = s;
    e.tc = cause_m[d];
    return e;
  endfunction

  task automatic step(input int d, input logic [3:0] op, input logic [3:0] fn,
                      input logic rdy, input logic r, input outv_t e);
    @(posedge clk);
    #1;
    if (d == 0) begin
      bus0.opcode = op; bus0.func_field = fn; bus0.mem_ready = rdy; rst0 = r;
      q0.push_back(e); id0.push_back(instr_id);
    end else begin
      bus1.opcode = op; bus1.func_field = fn; bus1.mem_ready = rdy; rst1 = r;
      q1.push_back(e); id1.push_back(instr_id);
    end
  endtask

  // Instruction semantics from the opcode table: class, ALU op, immediate use, sign-extend.
  task automatic ref_decode(input logic [3:0] op, input logic [3:0] fn, output int cls,
                            output logic [2:0] aop, output bit imm, output bit sx);
    cls = CAlu; aop = 3'b000; imm = 1'b0; sx = 1'b0;
    case (op)
      4'b1000: ;
      4'b1001: begin imm = 1'b1; sx = 1'b1; end
      4'b1010: imm = 1'b1;
      4'b1100: aop = 3'b001;
      4'b1101: begin aop = 3'b001; imm = 1'b1; sx = 1'b1; end
      4'b1110: begin aop = 3'b001; imm = 1'b1; end
      4'b1011: aop = 3'b010;
      4'b0111: begin aop = 3'b010; imm = 1'b1; end
      4'b1111: aop = 3'b101;
      4'b0110: begin aop = 3'b101; imm = 1'b1; sx = 1'b1; end
      4'b0000: begin
        if (fn == 4'd1) aop = 3'b011;
        else if (fn == 4'd2) aop = 3'b100;
        else if (fn == 4'd3) aop = 3'b111;
        else cls = CIll;
      end
      4'b0100, 4'b0101: cls = CBr;
      4'b0011: cls = CJmp;
      4'b0001: cls = CLw;
      4'b0010: cls = CSw;
      default: cls = CIll;
    endcase
  endtask

  // Access completes after lat idle cycles; gives up once tmo[d] idle cycles have elapsed.
  task automatic mem_phase(input int d, input logic [3:0] op, input logic [3:0] fn,
                           input state_e s, input int lat, output bit to);
    outv_t e;
    bit    rdy;
    to = 1'b0;
    for (int i = 0; i < 100; i++) begin
      rdy       = (i == lat);
      e         = base(d, s);
      e.mem_req = 1'b1;
      if (s == StFetch) begin
        e.mr = 1'b1; e.src_b = 3'b001; e.irw = rdy; e.pcw = rdy;
      end else if (s == StMemLw) begin
        e.mr = 1'b1;
      end else begin
        e.mw = 1'b1; e.rr2 = 1'b1; e.ret = rdy;
      end
      step(d, op, fn, rdy, 1'b0, e);
      if (rdy) break;
      if (tmo[d] != 0 && i == int'(tmo[d])) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_trap(input int d, input logic [3:0] op, input logic [3:0] fn,
                         input logic [1:0] c);
    outv_t e;
    cause_m[d] = c;
    e = base(d, StTrap); e.pc_src = 2'b10; e.pcw = 1'b1; e.tv = 1'b1;
    step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
  endtask

  task automatic addr_step(input int d, input logic [3:0] op);
    outv_t e;
    e = base(d, StExAddr);
    e.src_a = 1'b1; e.src_b = 3'b011; e.rr1 = 2'b10; e.rr2 = 1'b1; e.sext = 1'b1;
    step(d, op, 4'd0, 1'($urandom_range(0, 1)), 1'b0, e);
  endtask

  task automatic run_instr(input int d, input logic [3:0] op, input logic [3:0] fn,
                           input int lf, input int lm);
    outv_t      e;
    bit         to, imm, sx;
    int         cls;
    logic [2:0] aop;
    instr_id++;
    mem_phase(d, op, fn, StFetch, lf, to);
    if (to) begin
      do_trap(d, op, fn, 2'b10);
      return;
    end
    e = base(d, StDecode); e.src_b = 3'b001;
    step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
    ref_decode(op, fn, cls, aop, imm, sx);
    case (cls)
      CAlu: begin
        e = base(d, StExAlu);
        e.src_a = 1'b1; e.alu_op = aop; e.sext = sx;
        e.src_b = imm ? 3'b010 : 3'b000; e.rr1 = imm ? 2'b01 : 2'b00;
        step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
        e = base(d, StWbAlu); e.rw = 1'b1; e.rwd = 1'b1; e.ret = 1'b1;
        step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
      end
      CBr: begin
        e = base(d, StExBr);
        e.alu_op = 3'b001; e.src_a = 1'b1; e.rr1 = 2'b01; e.ret = 1'b1;
        e.beq = (op == 4'b0100); e.bnq = (op == 4'b0101);
        step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
      end
      CJmp: begin
        e = base(d, StExJmp); e.pc_src = 2'b01; e.src_b = 3'b100; e.pcw = 1'b1; e.ret = 1'b1;
        step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
      end
      CLw, CSw: begin
        addr_step(d, op);
        mem_phase(d, op, fn, (cls == CLw) ? StMemLw : StMemSw, lm, to);
        if (to) do_trap(d, op, fn, 2'b10);
        else if (cls == CLw) begin
          e = base(d, StWbLw); e.rw = 1'b1; e.m2r = 1'b1; e.ret = 1'b1;
          step(d, op, fn, 1'($urandom_range(0, 1)), 1'b0, e);
        end
      end
      default: if (toi[d]) do_trap(d, op, fn, 2'b01);
    endcase
  endtask

  task automatic reset_dut(input int d);
    outv_t e;
    cause_m[d] = 2'b00;
    e = base(d, StFetch); e.mem_req = 1'b1; e.mr = 1'b1; e.src_b = 3'b001;
    step(d, 4'd0, 4'd0, 1'b0, 1'b1, e);
    step(d, 4'd0, 4'd0, 1'b0, 1'b1, e);
  endtask

  function automatic int rand_lat();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return int'($urandom_range(0, 3));
    if (r == 6) return 14;
    if (r == 7) return 15;
    return int'($urandom_range(16, 22));
  endfunction

  task automatic rand_instr(input int d);
    logic [3:0] op, fn;
    op = 4'($urandom_range(0, 15));
    fn = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 15));
    run_instr(d, op, fn, rand_lat(), rand_lat());
  endtask

  initial begin
    outv_t e;
    bit    to;
    bus0.opcode = '0; bus0.func_field = '0; bus0.mem_ready = 1'b0;
    bus1.opcode = '0; bus1.func_field = '0; bus1.mem_ready = 1'b0;

    reset_dut(0);
    run_instr(0, 4'b1000, 4'd0, 0, 0);   // ADD, memory always ready
    run_instr(0, 4'b0001, 4'd0, 0, 2);   // LW, two wait cycles
    run_instr(0, 4'b0010, 4'd0, 0, 99);  // SW never ready -> timeout trap
    run_instr(0, 4'b0000, 4'd5, 1, 0);   // bad shift func -> illegal trap
    run_instr(0, 4'b0100, 4'd0, 0, 0);   // BEQ
    run_instr(0, 4'b0000, 4'd3, 0, 0);   // SRA
    run_instr(0, 4'b1000, 4'd0, 15, 0);  // ready coincides with the limit
    run_instr(0, 4'b1000, 4'd0, 16, 0);  // fetch timeout
    for (int n = 0; n < 150; n++) rand_instr(0);

    // Abort a pending load with reset after a trap has set a cause.
    run_instr(0, 4'b0000, 4'd9, 0, 0);
    instr_id++;
    mem_phase(0, 4'b0001, 4'd0, StFetch, 0, to);
    e = base(0, StDecode); e.src_b = 3'b001;
    step(0, 4'b0001, 4'd0, 1'b0, 1'b0, e);
    addr_step(0, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      e = base(0, StMemLw); e.mem_req = 1'b1; e.mr = 1'b1;
      step(0, 4'b0001, 4'd0, 1'b0, (i == 5), e);
    end
    cause_m[0] = 2'b00;
    run_instr(0, 4'b1000, 4'd0, 15, 0);

    reset_dut(1);
    run_instr(1, 4'b0000, 4'd5, 0, 0);   // illegal -> straight back to FETCH
    run_instr(1, 4'b0000, 4'd0, 0, 0);
    run_instr(1, 4'b1000, 4'd0, 20, 0);  // no timeout when disabled
    run_instr(1, 4'b0001, 4'd0, 0, 25);
    for (int n = 0; n < 40; n++) rand_instr(1);

    repeat (3) @(negedge clk);
    n_chk++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: got %0d/%0d pending required 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
